// File: rtl/adc_scan_scheduler_if.sv
// Scheduler <-> serial ADC engine request/response plus the result handshake
// toward the consumer. The scheduler takes the master side.
interface adc_scan_scheduler_if #(parameter int DATA_W = 12);
  logic              conv_req;
  logic [2:0]        conv_chan;
  logic              conv_ack;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;
  logic              res_valid;
  logic              res_ready;
  logic [2:0]        res_chan;
  logic [DATA_W-1:0] res_data;

  modport master (output conv_req, conv_chan, res_valid, res_chan, res_data,
                  input  conv_ack, conv_done, conv_data, res_ready);
  modport slave  (input  conv_req, conv_chan, res_valid, res_chan, res_data,
                  output conv_ack, conv_done, conv_data, res_ready);
endinterface

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel scan sequencer for a serial ADC engine: tick timer,
// channel walker FSM, conversion timeout, single-entry result register.
module adc_scan_scheduler #(
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          period,
  input  logic [7:0]           chan_mask,
  input  logic                 clear_flags,
  adc_scan_scheduler_if.master bus,
  output logic                 scan_done,
  output logic                 overrun,
  output logic                 tick_miss,
  output logic                 timeout_err
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, WAIT_DONE} state_t;
  typedef struct packed {
    logic [2:0]        chan;
    logic [DATA_W-1:0] data;
  } res_t;

  state_t        state, state_n;
  logic [15:0]   tick_cnt;
  logic          tick;
  logic [7:0]    mask_q;
  logic [2:0]    ptr, ptr_n;
  logic [TW-1:0] tmo_cnt;
  res_t          res_q;
  logic          res_vld;
  logic          start, res_ld, end_scan, tmo_hit, tmo_clr, miss;

  // Tick timer: counts period..0, ticks on 0 and reloads; parked at period when disabled.
  assign tick = enable && (tick_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst)                              tick_cnt <= period;
    else if (!enable || tick_cnt == 16'd0) tick_cnt <= period;
    else                                  tick_cnt <= tick_cnt - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    start    = 1'b0;
    res_ld   = 1'b0;
    end_scan = 1'b0;
    tmo_hit  = 1'b0;
    tmo_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (tick && chan_mask != 8'd0) begin
          start   = 1'b1;
          ptr_n   = 3'd0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (mask_q[ptr]) begin
          state_n = REQ;
        end else if (ptr == 3'd7) begin
          end_scan = 1'b1;
          state_n  = IDLE;
        end else begin
          ptr_n = ptr + 3'd1;
        end
      end
      REQ: begin
        if (bus.conv_ack) begin
          tmo_clr = 1'b1;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A late conv_done on the final timeout cycle still counts as a result.
        if (bus.conv_done) begin
          res_ld = 1'b1;
          if (ptr == 3'd7 || !enable) begin
            end_scan = 1'b1;
            state_n  = IDLE;
          end else begin
            ptr_n   = ptr + 3'd1;
            state_n = SELECT;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          end_scan = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign miss = tick && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 3'd0;
      mask_q  <= 8'd0;
      tmo_cnt <= '0;
    end else begin
      ptr <= ptr_n;
      if (start) mask_q <= chan_mask;
      if (tmo_clr)                 tmo_cnt <= '0;
      else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Single result slot: a load in the same cycle as a handshake keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_q   <= '0;
    end else if (res_ld) begin
      res_vld     <= 1'b1;
      res_q.chan  <= ptr;
      res_q.data  <= bus.conv_data;
    end else if (res_vld && bus.res_ready) begin
      res_vld <= 1'b0;
    end
  end

  // Sticky flags: a set event beats clear_flags in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
      tick_miss   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      scan_done <= end_scan;
      if (res_ld && res_vld && !bus.res_ready) overrun <= 1'b1;
      else if (clear_flags)                    overrun <= 1'b0;
      if (miss)             tick_miss <= 1'b1;
      else if (clear_flags) tick_miss <= 1'b0;
      if (tmo_hit)          timeout_err <= 1'b1;
      else if (clear_flags) timeout_err <= 1'b0;
    end
  end

  assign bus.conv_req  = (state == REQ);
  assign bus.conv_chan = ptr;
  assign bus.res_valid = res_vld;
  assign bus.res_chan  = res_q.chan;
  assign bus.res_data  = res_q.data;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Behavioral ADC engine queues each sample it returns; the result monitor pops
// and compares on every accepted res_valid&res_ready.
module tb_adc_scan_scheduler;
  localparam int DATA_W  = 12;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [2:0]        ch;
    logic [DATA_W-1:0] d;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period;
  logic [7:0]  chan_mask;
  logic        clear_flags;
  logic        scan_done, overrun, tick_miss, timeout_err;

  adc_scan_scheduler_if #(.DATA_W(DATA_W)) bus ();

  adc_scan_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .chan_mask(chan_mask),
    .clear_flags(clear_flags), .bus(bus), .scan_done(scan_done), .overrun(overrun),
    .tick_miss(tick_miss), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0, cyc = 0;
  int   done_dly = 20, done_cnt = 0, seq = 0, sd_cnt = 0, pop_cnt = 0;
  bit   eng_mute = 1'b0, mon_en = 1'b1;
  rec_t exp_q[$];
  int   sd_cyc[$];
  logic [2:0] got_ch[$];
  int   t1_ch[3] = '{0, 2, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_sd(input string tag, input int bound);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk); #1;
      hit = scan_done;
    end
    if (!hit) chk(tag, 32'(0), 32'(1));
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : engine
    logic [2:0]        ch;
    logic [DATA_W-1:0] d;
    bus.conv_ack  = 1'b0;
    bus.conv_done = 1'b0;
    bus.conv_data = '0;
    forever begin
      @(negedge clk);
      if (bus.conv_req) begin
        ch = bus.conv_chan;
        bus.conv_ack = 1'b1;
        @(negedge clk);
        bus.conv_ack = 1'b0;
        if (!eng_mute) begin
          repeat (done_dly - 1) @(negedge clk);
          d = DATA_W'(seq * 97 + 5 * int'(ch) + 3);
          seq++;
          bus.conv_data = d;
          bus.conv_done = 1'b1;
          exp_q.push_back('{ch: ch, d: d});
          done_cnt++;
          @(negedge clk);
          bus.conv_done = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.res_valid && bus.res_ready) begin
        pop_cnt++;
        got_ch.push_back(bus.res_chan);
        if (exp_q.size() == 0) chk("res_unexpected", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("res_chan", 32'(bus.res_chan), 32'(e.ch));
          chk("res_data", 32'(bus.res_data), 32'(e.d));
        end
      end
      if (scan_done) begin
        sd_cnt++;
        sd_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, sd0, pc0, dc0;
    bit seen;
    rst = 1'b1; enable = 1'b0; period = 16'd100; chan_mask = 8'd0;
    clear_flags = 1'b0; bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_conv_req",  32'(bus.conv_req), 32'(0));
    chk("rst_conv_chan", 32'(bus.conv_chan), 32'(0));
    chk("rst_res_valid", 32'(bus.res_valid), 32'(0));
    chk("rst_scan_done", 32'(scan_done), 32'(0));
    chk("rst_flags",     32'({overrun, tick_miss, timeout_err}), 32'(0));
    rst = 1'b0;

    // periodic scan of ch 0,2,7
    chan_mask = 8'b1000_0101; done_dly = 20;
    got_ch.delete(); sd_cyc.delete(); sd0 = sd_cnt;
    @(negedge clk);
    enable = 1'b1;
    for (int s = 0; s < 3; s++) wait_sd("t1_scan_wait", 1000);
    enable = 1'b0;
    @(negedge clk);
    chk("t1_scans", 32'(sd_cnt - sd0), 32'(3));
    chk("t1_nres", 32'(got_ch.size()), 32'(9));
    for (int i = 0; i < 9 && i < got_ch.size(); i++)
      chk("t1_chan_order", 32'(got_ch[i]), 32'(t1_ch[i % 3]));
    if (sd_cyc.size() >= 3) begin
      chk("t1_interval_a", 32'(sd_cyc[1] - sd_cyc[0]), 32'(101));
      chk("t1_interval_b", 32'(sd_cyc[2] - sd_cyc[1]), 32'(101));
    end
    chk("t1_flags", 32'({overrun, tick_miss, timeout_err}), 32'(0));

    // overrun: consumer stalled across two conversions
    mon_en = 1'b0; bus.res_ready = 1'b0; exp_q.delete();
    period = 16'd250; chan_mask = 8'h03;
    @(negedge clk);
    enable = 1'b1;
    wait_sd("t2_scan_wait", 600);
    enable = 1'b0;
    @(negedge clk);
    chk("t2_overrun", 32'(overrun), 32'(1));
    chk("t2_valid", 32'(bus.res_valid), 32'(1));
    chk("t2_nexp", 32'(exp_q.size()), 32'(2));
    if (exp_q.size() == 2) chk("t2_data_second", 32'(bus.res_data), 32'(exp_q[1].d));
    chk("t2_chan_second", 32'(bus.res_chan), 32'(1));
    pulse_clear();
    chk("t2_overrun_clr", 32'(overrun), 32'(0));
    chk("t2_valid_held", 32'(bus.res_valid), 32'(1));
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drained", 32'(bus.res_valid), 32'(0));

    // handshake and new load in the same cycle
    bus.res_ready = 1'b0; exp_q.delete(); n = 0; sd0 = sd_cnt;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 600 && n < 2; i++) begin
      @(negedge clk); #1;
      if (bus.conv_done) n++;
    end
    chk("t3_dones", 32'(n), 32'(2));
    chk("t3_pending", 32'(bus.res_valid), 32'(1));
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_kept", 32'(bus.res_valid), 32'(1));
    if (exp_q.size() == 2) chk("t3_data_new", 32'(bus.res_data), 32'(exp_q[1].d));
    chk("t3_overrun", 32'(overrun), 32'(0));
    enable = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_drain", 32'(bus.res_valid), 32'(0));
    chk("t3_one_scan", 32'(sd_cnt - sd0), 32'(1));
    exp_q.delete(); mon_en = 1'b1;

    // conversion timeout, then the next tick restarts the scan
    eng_mute = 1'b1; period = 16'd1000; chan_mask = 8'h04; sd0 = sd_cnt;
    @(negedge clk);
    enable = 1'b1; seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.conv_ack;
    end
    chk("t4_ack_seen", 32'(seen), 32'(1));
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 400 && !timeout_err; i++) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_tmo_cycles", 32'(n), 32'(TIMEOUT));
    chk("t4_tmo_flag", 32'(timeout_err), 32'(1));
    chk("t4_tmo_sd", 32'(scan_done), 32'(1));
    chk("t4_tmo_req", 32'(bus.conv_req), 32'(0));
    eng_mute = 1'b0; pc0 = pop_cnt;
    for (int i = 0; i < 1200 && !bus.conv_req; i++) @(negedge clk);
    chk("t4_restart_req", 32'(bus.conv_req), 32'(1));
    chk("t4_restart_chan", 32'(bus.conv_chan), 32'(2));
    wait_sd("t4_restart_wait", 300);
    enable = 1'b0;
    @(negedge clk);
    chk("t4_scans", 32'(sd_cnt - sd0), 32'(2));
    chk("t4_result", 32'(pop_cnt - pc0), 32'(1));
    chk("t4_tmo_sticky", 32'(timeout_err), 32'(1));
    chk("t4_no_miss", 32'(tick_miss), 32'(0));
    pulse_clear();
    chk("t4_tmo_clr", 32'(timeout_err), 32'(0));

    // fast ticks against a slow 8-channel scan
    period = 16'd5; chan_mask = 8'hFF; sd0 = sd_cnt; pc0 = pop_cnt;
    @(negedge clk);
    enable = 1'b1;
    wait_sd("t5_scan_wait", 3000);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_tick_miss", 32'(tick_miss), 32'(1));
    chk("t5_results", 32'(pop_cnt - pc0), 32'(8));
    repeat (50) @(negedge clk);
    chk("t5_no_extra_scan", 32'(sd_cnt - sd0), 32'(1));
    chk("t5_idle_req", 32'(bus.conv_req), 32'(0));
    pulse_clear();

    // latency for channel 0, set-beats-clear, enable drop mid-scan
    period = 16'd0; chan_mask = 8'h01;
    repeat (2) @(negedge clk);
    enable = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!bus.conv_req && n < 20);
    chk("lat_ch0", 32'(n), 32'(2));
    pulse_clear();
    chk("t6_set_wins", 32'(tick_miss), 32'(1));
    enable = 1'b0;
    wait_sd("t6_scan_wait", 200);
    @(negedge clk);
    pulse_clear();
    chk("t6_miss_clr", 32'(tick_miss), 32'(0));

    chan_mask = 8'h08; pc0 = pop_cnt; sd0 = sd_cnt;
    @(negedge clk);
    enable = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!bus.conv_req && n < 20);
    chk("lat_ch3", 32'(n), 32'(5));
    enable = 1'b0;
    wait_sd("t6_drop_wait", 200);
    @(negedge clk);
    chk("t6_drop_result", 32'(pop_cnt - pc0), 32'(1));
    chk("t6_drop_scans", 32'(sd_cnt - sd0), 32'(1));
    pulse_clear();

    // reset while waiting for conv_done
    done_dly = 30; chan_mask = 8'h01; mon_en = 1'b0; exp_q.delete(); dc0 = done_cnt;
    @(negedge clk);
    enable = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.conv_ack;
    end
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_miss_before", 32'(tick_miss), 32'(1));
    sd0 = sd_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_rst_req", 32'(bus.conv_req), 32'(0));
    chk("t7_rst_miss", 32'(tick_miss), 32'(0));
    for (int i = 0; i < 60 && done_cnt == dc0; i++) @(negedge clk);
    chk("t7_done_sent", 32'(done_cnt - dc0), 32'(1));
    repeat (3) @(negedge clk);
    chk("t7_no_result", 32'(bus.res_valid), 32'(0));
    chk("t7_no_req", 32'(bus.conv_req), 32'(0));
    chk("t7_no_sd", 32'(sd_cnt - sd0), 32'(0));
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
